sprite_compositor: RTL

- Parametrised successor to the single-sprite pixel mux in the game top level.
- Overlays NUM_SPRITES solid-colour rectangular sprites onto a background pixel stream with fixed priority and a transparency key.
- Delays the XVGA sync and blank signals so they stay aligned with the composited pixel.
- Latches sprite positions once per frame so nothing tears mid-frame, and reports per-frame sprite collisions to game logic.

---
 rtl/sprite_compositor_if.sv | 35 +++
 rtl/sprite_compositor.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sprite_compositor_if.sv
// Pixel-stream and sprite-configuration bundle for sprite_compositor.
// Raw scan counters, syncs and sprite attributes flow in; composited video and frame status flow out.
interface sprite_compositor_if #(
    parameter int NUM_SPRITES = 4
);
    logic [10:0]               hcount_in;
    logic [9:0]                vcount_in;
    logic                      hsync_in;
    logic                      vsync_in;
    logic                      blank_in;
    logic [11:0]               bg_pixel_in;
    logic [11*NUM_SPRITES-1:0] spr_x_in;
    logic [10*NUM_SPRITES-1:0] spr_y_in;
    logic [12*NUM_SPRITES-1:0] spr_color_in;
    logic [NUM_SPRITES-1:0]    spr_en_in;

    logic                      phsync_out;
    logic                      pvsync_out;
    logic                      pblank_out;
    logic [11:0]               pixel_out;
    logic                      frame_out;
    logic [NUM_SPRITES-1:0]    collision_out;

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, blank_in, bg_pixel_in,
               spr_x_in, spr_y_in, spr_color_in, spr_en_in,
        output phsync_out, pvsync_out, pblank_out, pixel_out, frame_out, collision_out
    );

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, blank_in, bg_pixel_in,
               spr_x_in, spr_y_in, spr_color_in, spr_en_in,
        input  phsync_out, pvsync_out, pblank_out, pixel_out, frame_out, collision_out
    );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage sprite overlay: stage 1 hit-tests against per-frame shadow copies of the sprite
// attributes, stage 2 muxes the pixel and tracks sprite collisions for the current frame.
module sprite_compositor #(
    parameter int          NUM_SPRITES = 4,
    parameter int          SPR_W       = 16,
    parameter int          SPR_H       = 16,
    parameter logic [11:0] TRANSP      = 12'h000
) (
    input  logic           vclk_in,
    input  logic           rst_n_in,
    sprite_compositor_if.slave bus
);
    typedef logic [NUM_SPRITES-1:0] mask_t;

    logic [10:0] sh_x     [NUM_SPRITES];
    logic [9:0]  sh_y     [NUM_SPRITES];
    logic [11:0] sh_color [NUM_SPRITES];
    mask_t       sh_vis;

    logic        frame_start;
    mask_t       hit;
    logic [11:0] spr_pix;

    mask_t       hit_q;
    logic        any_hit_q;
    logic [11:0] spr_pix_q;
    logic [11:0] bg_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        blank_q;

    mask_t       acc;
    mask_t       contrib;

    assign frame_start = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);

    // Enable and transparency fold into one visibility bit when the shadows are captured.
    always_ff @(posedge vclk_in) begin
        if (!rst_n_in) begin
            // NOTE: the shadow arrays are a handful of flops, not RAM, so resetting them is cheap and
            // guarantees nothing is drawn before the first frame start.
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i]     <= '0;
                sh_y[i]     <= '0;
                sh_color[i] <= '0;
            end
            sh_vis <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x[i]     <= bus.spr_x_in[11*i +: 11];
                sh_y[i]     <= bus.spr_y_in[10*i +: 10];
                sh_color[i] <= bus.spr_color_in[12*i +: 12];
                sh_vis[i]   <= bus.spr_en_in[i] && (bus.spr_color_in[12*i +: 12] != TRANSP);
            end
        end
    end

    // Bounds use one extra bit so a sprite hanging off the right or bottom edge clips instead of wrapping.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
        hit     = '0;
        spr_pix = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit[i] = sh_vis[i]
                  && ({1'b0, bus.hcount_in} >= {1'b0, sh_x[i]})
                  && ({1'b0, bus.hcount_in} <  ({1'b0, sh_x[i]} + 12'(SPR_W)))
                  && ({1'b0, bus.vcount_in} >= {1'b0, sh_y[i]})
                  && ({1'b0, bus.vcount_in} <  ({1'b0, sh_y[i]} + 11'(SPR_H)));
        end
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) spr_pix = sh_color[i];
        end
    end

    // The sprite colour is resolved here so a frame-start pixel never mixes old positions with new colours.
    always_ff @(posedge vclk_in) begin
        if (!rst_n_in) begin
            hit_q     <= '0;
            any_hit_q <= 1'b0;
            spr_pix_q <= '0;
            bg_q      <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_q   <= 1'b1;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            hit_q     <= hit;
            any_hit_q <= |hit;
            spr_pix_q <= spr_pix;
            bg_q      <= bus.bg_pixel_in;
            hsync_q   <= bus.hsync_in;
            vsync_q   <= bus.vsync_in;
            blank_q   <= bus.blank_in;
        end
    end

    // Clearing the lowest set bit leaves something only when two or more sprites hit.
    assign contrib = (!blank_q && ((hit_q & (hit_q - 1'b1)) != '0)) ? hit_q : '0;

    always_ff @(posedge vclk_in) begin
        if (!rst_n_in) begin
            bus.phsync_out    <= 1'b1;
            bus.pvsync_out    <= 1'b1;
            bus.pblank_out    <= 1'b1;
            bus.pixel_out     <= '0;
            bus.frame_out     <= 1'b0;
            bus.collision_out <= '0;
            acc               <= '0;
        end else begin
            bus.phsync_out <= hsync_q;
            bus.pvsync_out <= vsync_q;
            bus.pblank_out <= blank_q;
            bus.pixel_out  <= blank_q ? 12'h000 : (any_hit_q ? spr_pix_q : bg_q);
            bus.frame_out  <= frame_start;
            if (frame_start) begin
                bus.collision_out <= acc;
                acc               <= contrib;
            end else begin
                acc <= acc | contrib;
            end
        end
    end
endmodule
